fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Producer side of the instruction buffer. Holds the fetch PC, issues one 64-bit block request at a time to the
//  I-cache/memory port, and slices each response into up to FETCH_W INST_PACKETs for the buffer's fill port.
//  Fills only when open_entries allows; on br_en it drops in-flight work and restarts at br_target_pc.
//  Static predict-not-taken: next PC is always sequential.
// PARAMETERS
//  FETCH_W     2                  insts per 64-bit block (32-bit insts)
//  DEPTH       `INST_BUFF_DEPTH   buffer depth; sizes open_entries/num_out
//  RESET_PC    32'h0              PC loaded on reset
// PORTS
//  clock            in   1                     clock
//  reset            in   1                     synchronous, active-high
//  br_en            in   1                     mispredict squash/redirect, one-cycle pulse
//  br_target_pc     in   32                    redirect PC, word aligned
//  open_entries     in   $clog2(DEPTH+1)       free buffer slots this cycle
//  mem_req_valid    out  1                     block request valid
//  mem_req_addr     out  32                    block address, {pc[31:3],3'b0}
//  mem_req_ready    in   1                     request accepted when valid&&ready
//  mem_rsp_valid    in   1                     response data valid, in order, one per request
//  mem_rsp_data     in   64                    word0 = [31:0], word1 = [63:32]
//  out_insts        out  INST_PACKET[FETCH_W]  to buffer in_insts[FETCH_W-1:0]; upper slots '0
//  num_out          out  $clog2(DEPTH+1)       to buffer num_accept, 0..FETCH_W
// BEHAVIOUR
//  - FSM states: IDLE, WAIT (request accepted, no response yet), HOLD (response latched, no room),
//    SQUASH (response owed but stale).
//  - Reset: pc=RESET_PC, state=IDLE, hold reg='0, mem_req_valid=0, num_out=0, out_insts='0.
//  - IDLE: mem_req_valid=1, mem_req_addr=block(pc). On ready go to WAIT.
//  - WAIT with mem_rsp_valid:
//    - cnt = pc[2] ? 1 : 2. Word0 is used only when pc[2]=0.
//    - If open_entries>=cnt: emit num_out=cnt in the same cycle (combinational from rsp).
//      Then pc += 4*cnt and go to IDLE.
//    - Otherwise latch the data, go to HOLD, num_out=0.
//  - HOLD: emit from the latched data in the first cycle with open_entries>=cnt.
//    Then pc += 4*cnt and go to IDLE.
//  - Packets:
//    - slot0 = first valid word of the block.
//    - Fields: inst=word, PC=its address, NPC=PC+4, valid=1.
//    - Unused slots '0.
//  - br_en (priority over all other events, any state):
//    - pc <= br_target_pc; num_out=0 and mem_req_valid=0 that cycle. The buffer flushes the same cycle.
//    - From IDLE/HOLD go to IDLE; HOLD data is discarded.
//    - From WAIT: if mem_rsp_valid is also high that cycle the response is consumed and dropped, go to IDLE.
//      Otherwise go to SQUASH.
//    - From SQUASH: stay in SQUASH.
//  - SQUASH: mem_req_valid=0. The next mem_rsp_valid is dropped (num_out=0), then go to IDLE.
//  - At most one outstanding request; never request in WAIT/HOLD/SQUASH.
//  - IDLE with mem_req_valid && !ready: hold addr stable; the request may be withdrawn only by br_en.
//  - PC arithmetic is 32-bit modulo; wrap at 2^32 is legal.
//  - num_out <= open_entries always, so the buffer never overflows.
// STRUCTURE
//  - sys_defs.svh: INST_PACKET (inst, PC, NPC, valid), `FETCH_W, `INST_BUFF_DEPTH, RESET_PC define,
//    FETCH_STATE enum.
//  - Sub-module fetch_block_align (combinational): (data64, pc, cnt) -> out_insts.
//    Shared by the WAIT bypass and HOLD paths.
//  - `ifdef DEBUG: export debug_state and debug_pc.
// TESTING
//  1. Reset with RESET_PC=0, mem always ready, 1-cycle rsp 64'hBBBB_BBBB_AAAA_AAAA, open_entries=8:
//     num_out=2, insts AAAA_AAAA@0 and BBBB_BBBB@4; next req addr 8.
//  2. br_target_pc=32'h104 (odd word):
//     req addr 0x100, num_out=1 with word1 @0x104, NPC=0x108; next req 0x108.
//  3. open_entries=1 at aligned rsp:
//     state HOLD, num_out=0, no new req; raise open_entries=2 -> num_out=2 that cycle, then IDLE.
//  4. br_en to 0x200 while WAIT, rsp 2 cycles later:
//     that rsp dropped (num_out=0), then req 0x200 issued.
//  5. br_en to 0x300 same cycle as rsp_valid:
//     num_out=0, next cycle IDLE req 0x300, no SQUASH.
//  6. mem_req_ready low 3 cycles:
//     addr stable, one request only; reset asserted in HOLD -> IDLE with pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared types and defaults for the fetch unit and its block aligner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int          FETCH_W_DEFAULT  = 2;
  localparam int          INST_BUFF_DEPTH  = 8;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } INST_PACKET;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HOLD   = 2'd2,
    FETCH_SQUASH = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_block_align.sv
// ============================================================================
// Module : fetch_block_align
// Brief  : Slices one fetch block into packets starting at the PC's word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_block_align
  import fetch_unit_pkg::*;
#(
  parameter int FETCH_W = FETCH_W_DEFAULT,
  parameter int CNT_W   = 4
) (
  input  logic [32*FETCH_W-1:0]  data_i,
  input  logic [29:0]            word_pc_i,
  input  logic [CNT_W-1:0]       cnt_i,
  output INST_PACKET [FETCH_W-1:0] insts_o
);

  localparam int WIDX_W = $clog2(FETCH_W);

  logic [31:0]       words [FETCH_W];
  logic [WIDX_W-1:0] start;
  logic [29:0]       blk_word;

  assign start    = word_pc_i[WIDX_W-1:0];
  assign blk_word = {word_pc_i[29:WIDX_W], {WIDX_W{1'b0}}};

  for (genvar w = 0; w < FETCH_W; w++) begin : g_word
    assign words[w] = data_i[32*w +: 32];
  end

  for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
    logic [WIDX_W:0] idx;
    logic [31:0]     addr;
    INST_PACKET      pkt;

    assign idx  = {1'b0, start} + (WIDX_W+1)'(i);
    assign addr = {blk_word + 30'(idx), 2'b00};

    always_comb begin
      pkt = '0;
      if ((CNT_W'(i) < cnt_i) && (idx < (WIDX_W+1)'(FETCH_W))) begin
        pkt.inst  = words[idx[WIDX_W-1:0]];
        pkt.PC    = addr;
        pkt.NPC   = addr + 32'd4;
        pkt.valid = 1'b1;
      end
    end

    assign insts_o[i] = pkt;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Single-outstanding block fetcher feeding the instruction buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          FETCH_W  = FETCH_W_DEFAULT,
  parameter int          DEPTH    = INST_BUFF_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef DEBUG
  output logic [1:0]                 debug_state,
  output logic [31:0]                debug_pc,
`endif
  input  logic                       br_en,
  input  logic [31:0]                br_target_pc,
  input  logic [$clog2(DEPTH+1)-1:0] open_entries,
  output logic                       mem_req_valid,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [32*FETCH_W-1:0]      mem_rsp_data,
  output INST_PACKET [FETCH_W-1:0]   out_insts,
  output logic [$clog2(DEPTH+1)-1:0] num_out
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WIDX_W = $clog2(FETCH_W);
  localparam int BLK_W  = 32 * FETCH_W;

  fetch_state_e             state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [BLK_W-1:0]         hold_q, hold_d;
  logic                     req, emit, use_hold, emit_out;
  logic [CNT_W-1:0]         cnt;
  logic                     room;
  logic [BLK_W-1:0]         blk_data;
  INST_PACKET [FETCH_W-1:0] aligned;

  // Words remaining in the current block from the PC onward.
  assign cnt  = CNT_W'(FETCH_W) - CNT_W'(pc_q[2 +: WIDX_W]);
  assign room = (open_entries >= cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    req      = 1'b0;
    emit     = 1'b0;
    use_hold = 1'b0;
    if (br_en) begin
      pc_d   = br_target_pc;
      hold_d = '0;
      // A response arriving with the redirect is the owed one; consume it here.
      case (state_q)
        FETCH_WAIT, FETCH_SQUASH: state_d = mem_rsp_valid ? FETCH_IDLE : FETCH_SQUASH;
        default:                  state_d = FETCH_IDLE;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          req = 1'b1;
          if (mem_req_ready) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (mem_rsp_valid) begin
            if (room) begin
              emit    = 1'b1;
              pc_d    = pc_q + (32'(cnt) << 2);
              state_d = FETCH_IDLE;
            end else begin
              hold_d  = mem_rsp_data;
              state_d = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          use_hold = 1'b1;
          if (room) begin
            emit    = 1'b1;
            pc_d    = pc_q + (32'(cnt) << 2);
            state_d = FETCH_IDLE;
          end
        end
        FETCH_SQUASH: begin
          if (mem_rsp_valid) state_d = FETCH_IDLE;
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  assign blk_data = use_hold ? hold_q : mem_rsp_data;

  fetch_block_align #(
    .FETCH_W (FETCH_W),
    .CNT_W   (CNT_W)
  ) u_align (
    .data_i    (blk_data),
    .word_pc_i (pc_q[31:2]),
    .cnt_i     (cnt),
    .insts_o   (aligned)
  );

  assign emit_out      = emit && !reset;
  assign mem_req_valid = req && !reset;
  assign mem_req_addr  = {pc_q[31:WIDX_W+2], {(WIDX_W+2){1'b0}}};
  assign num_out       = emit_out ? cnt : '0;
  assign out_insts     = emit_out ? aligned : '0;

`ifdef DEBUG
  assign debug_state = state_q;
  assign debug_pc    = pc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed scenarios plus randomized run against a transaction model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              br_en;
  logic [31:0]       br_target_pc;
  logic [3:0]        open_entries;
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;
  INST_PACKET [1:0]  out_insts;
  logic [3:0]        num_out;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.FETCH_W(2), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .br_en         (br_en),
    .br_target_pc  (br_target_pc),
    .open_entries  (open_entries),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_insts     (out_insts),
    .num_out       (num_out)
  );

  always #5 clock = ~clock;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic INST_PACKET mkpkt(input logic [31:0] inst, input logic [31:0] pc);
    INST_PACKET p;
    p.inst = inst; p.PC = pc; p.NPC = pc + 32'd4; p.valid = 1'b1;
    return p;
  endfunction

  task automatic test_reset;
    reset = 1; br_en = 0; br_target_pc = 0; open_entries = 8;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (num_out !== 4'd0) begin failures++; $display("FAIL reset_num_out got=%0d exp=0", num_out); end
    checks++; if (out_insts !== '0) begin failures++; $display("FAIL reset_out_insts got=%h exp=0", out_insts); end
    @(negedge clock); reset = 0; #1;
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b exp=1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_first_addr got=%h exp=0", mem_req_addr); end
  endtask

  task automatic test_aligned;
    mem_req_ready = 1;
    @(negedge clock);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hBBBB_BBBB_AAAA_AAAA; #1;
    checks++; if (num_out !== 4'd2) begin failures++; $display("FAIL aligned_num got=%0d exp=2", num_out); end
    checks++; if (out_insts[0] !== mkpkt(32'hAAAA_AAAA, 32'h0)) begin failures++; $display("FAIL aligned_slot0 got=%h exp=%h", out_insts[0], mkpkt(32'hAAAA_AAAA, 32'h0)); end
    checks++; if (out_insts[1] !== mkpkt(32'hBBBB_BBBB, 32'h4)) begin failures++; $display("FAIL aligned_slot1 got=%h exp=%h", out_insts[1], mkpkt(32'hBBBB_BBBB, 32'h4)); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL aligned_no_req got=%b exp=0", mem_req_valid); end
    @(negedge clock); mem_rsp_valid = 0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin failures++; $display("FAIL aligned_next_req got=%b/%h exp=1/00000008", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_odd_target;
    @(negedge clock); br_en = 1; br_target_pc = 32'h104; #1;
    checks++; if (mem_req_valid !== 1'b0 || num_out !== 4'd0) begin failures++; $display("FAIL br_quiet got=%b/%0d exp=0/0", mem_req_valid, num_out); end
    @(negedge clock); br_en = 0; mem_req_ready = 1; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin failures++; $display("FAIL odd_req got=%b/%h exp=1/00000100", mem_req_valid, mem_req_addr); end
    @(negedge clock); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = {32'h1111_1111, 32'h2222_2222}; #1;
    checks++; if (num_out !== 4'd1) begin failures++; $display("FAIL odd_num got=%0d exp=1", num_out); end
    checks++; if (out_insts[0] !== mkpkt(32'h1111_1111, 32'h104)) begin failures++; $display("FAIL odd_slot0 got=%h exp=%h", out_insts[0], mkpkt(32'h1111_1111, 32'h104)); end
    checks++; if (out_insts[1] !== '0) begin failures++; $display("FAIL odd_slot1 got=%h exp=0", out_insts[1]); end
    @(negedge clock); mem_rsp_valid = 0; mem_req_ready = 1; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h108) begin failures++; $display("FAIL odd_next_req got=%b/%h exp=1/00000108", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_hold;
    @(negedge clock); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hDDDD_0002_CCCC_0001; open_entries = 1; #1;
    checks++; if (num_out !== 4'd0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL hold_enter got=%0d/%b exp=0/0", num_out, mem_req_valid); end
    @(negedge clock); mem_rsp_valid = 0; mem_rsp_data = {$urandom, $urandom}; #1;
    checks++; if (num_out !== 4'd0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL hold_wait got=%0d/%b exp=0/0", num_out, mem_req_valid); end
    @(negedge clock); open_entries = 2; #1;
    checks++; if (num_out !== 4'd2) begin failures++; $display("FAIL hold_num got=%0d exp=2", num_out); end
    checks++; if (out_insts[0] !== mkpkt(32'hCCCC_0001, 32'h108)) begin failures++; $display("FAIL hold_slot0 got=%h exp=%h", out_insts[0], mkpkt(32'hCCCC_0001, 32'h108)); end
    checks++; if (out_insts[1] !== mkpkt(32'hDDDD_0002, 32'h10C)) begin failures++; $display("FAIL hold_slot1 got=%h exp=%h", out_insts[1], mkpkt(32'hDDDD_0002, 32'h10C)); end
    @(negedge clock); open_entries = 8; mem_req_ready = 1; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h110) begin failures++; $display("FAIL hold_next_req got=%b/%h exp=1/00000110", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_squash_wait;
    @(negedge clock); mem_req_ready = 0; br_en = 1; br_target_pc = 32'h200; #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL sqw_br got=%b exp=0", mem_req_valid); end
    @(negedge clock); br_en = 0; #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL sqw_idle got=%b exp=0", mem_req_valid); end
    @(negedge clock); mem_rsp_valid = 1; mem_rsp_data = {$urandom, $urandom}; #1;
    checks++; if (num_out !== 4'd0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL sqw_drop got=%0d/%b exp=0/0", num_out, mem_req_valid); end
    @(negedge clock); mem_rsp_valid = 0; mem_req_ready = 1; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin failures++; $display("FAIL sqw_req got=%b/%h exp=1/00000200", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_squash_same_cycle;
    @(negedge clock); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = {$urandom, $urandom};
    br_en = 1; br_target_pc = 32'h300; #1;
    checks++; if (num_out !== 4'd0) begin failures++; $display("FAIL sqs_drop got=%0d exp=0", num_out); end
    @(negedge clock); mem_rsp_valid = 0; br_en = 0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin failures++; $display("FAIL sqs_req got=%b/%h exp=1/00000300", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_stall_and_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); mem_req_ready = 0; #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/00000300", mem_req_valid, mem_req_addr); end
    end
    @(negedge clock); mem_req_ready = 1;
    @(negedge clock); mem_req_ready = 0; #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_single got=%b exp=0", mem_req_valid); end
    @(negedge clock); mem_rsp_valid = 1; mem_rsp_data = {$urandom, $urandom}; open_entries = 0; #1;
    checks++; if (num_out !== 4'd0) begin failures++; $display("FAIL stall_full got=%0d exp=0", num_out); end
    @(negedge clock); mem_rsp_valid = 0; reset = 1; open_entries = 8;
    @(negedge clock); reset = 0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0 || num_out !== 4'd0) begin failures++; $display("FAIL hold_reset got=%b/%h/%0d exp=1/00000000/0", mem_req_valid, mem_req_addr, num_out); end
  endtask

  // Randomized run: memory with random latency/readiness, random buffer space and redirects.
  task automatic test_random;
    logic [31:0] exp_pc, rsp_addr, tgt;
    bit          owed, stale, held, rsp_now, br, exp_req;
    int          dly, cnt, exp_num;
    INST_PACKET  ep;
    reset = 1; br_en = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    @(negedge clock); reset = 0;
    exp_pc = 32'h0; rsp_addr = 0; owed = 0; stale = 0; held = 0; dly = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      rsp_now       = owed && (dly == 0);
      mem_rsp_valid = rsp_now;
      mem_rsp_data  = rsp_now ? {memw(rsp_addr + 32'd4), memw(rsp_addr)} : {$urandom, $urandom};
      br            = ($urandom_range(0, 15) == 0) && !(stale && rsp_now);
      tgt           = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      br_en         = br;
      br_target_pc  = tgt;
      mem_req_ready = ($urandom_range(0, 3) != 0);
      open_entries  = 4'($urandom_range(0, 8));
      #1;
      cnt     = exp_pc[2] ? 1 : 2;
      exp_req = !br && !owed && !held;
      exp_num = (!br && ((rsp_now && !stale) || held) && (int'(open_entries) >= cnt)) ? cnt : 0;
      checks++; if (mem_req_valid !== exp_req) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", n, mem_req_valid, exp_req); end
      if (exp_req) begin
        checks++; if (mem_req_addr !== {exp_pc[31:3], 3'b000}) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", n, mem_req_addr, {exp_pc[31:3], 3'b000}); end
      end
      checks++; if (num_out !== 4'(exp_num)) begin failures++; $display("FAIL rnd_num_out cyc=%0d got=%0d exp=%0d", n, num_out, exp_num); end
      for (int s = 0; s < 2; s++) begin
        ep = (s < exp_num) ? mkpkt(memw(exp_pc + 32'(4 * s)), exp_pc + 32'(4 * s)) : '0;
        checks++; if (out_insts[s] !== ep) begin failures++; $display("FAIL rnd_slot%0d cyc=%0d got=%h exp=%h", s, n, out_insts[s], ep); end
      end
      if (owed && !rsp_now) dly--;
      if (br) begin
        exp_pc = tgt; held = 0;
        if (owed && rsp_now) begin owed = 0; stale = 0; end
        else if (owed) stale = 1;
      end else begin
        if (rsp_now) begin
          owed = 0;
          if (stale) stale = 0;
          else if (int'(open_entries) >= cnt) exp_pc = exp_pc + 32'(4 * cnt);
          else held = 1;
        end else if (held && int'(open_entries) >= cnt) begin
          held = 0; exp_pc = exp_pc + 32'(4 * cnt);
        end
        if (exp_req && mem_req_ready) begin
          owed = 1; rsp_addr = {exp_pc[31:3], 3'b000}; dly = $urandom_range(0, 2);
        end
      end
    end
    br_en = 0; mem_rsp_valid = 0;
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_odd_target;
    test_hold;
    test_squash_wait;
    test_squash_same_cycle;
    test_stall_and_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
